// File: rtl/count_limit_monitor.sv
// Over-limit monitor for a checker counter: tracks the high-water mark and raises one
// valid/ready violation report per sustained over-limit run of HOLD enabled samples.
module count_limit_monitor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned TOT_W = 16
) (
  input  logic             clk_ev,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  input  logic [31:0]      max,
  output logic             over,
  output logic [WIDTH-1:0] peak,
  output logic             viol_valid,
  input  logic             viol_ready,
  output logic [WIDTH-1:0] viol_count,
  output logic [WIDTH-1:0] viol_peak,
  output logic [TOT_W-1:0] viol_total
);

  localparam int unsigned RUN_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_REPORT,
    S_RECOVER
  } state_t;

  state_t             r_state;
  logic [RUN_W-1:0]   r_run;
  logic               r_over;
  logic [WIDTH-1:0]   r_peak;
  logic               r_viol_valid;
  logic [WIDTH-1:0]   r_viol_count;
  logic [WIDTH-1:0]   r_viol_peak;
  logic [TOT_W-1:0]   r_viol_total;

  logic [WIDTH-1:0]   w_limit;
  logic               w_cmp;
  logic [WIDTH-1:0]   w_peak_next;

  // A negative limit means every count is over; otherwise the low 31 bits act as an unsigned limit.
  assign w_limit     = WIDTH'({1'b0, max[30:0]});
  assign w_cmp       = max[31] | (count >= w_limit);
  assign w_peak_next = (count > r_peak) ? count : r_peak;

  always_ff @(posedge clk_ev) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_run        <= '0;
      r_over       <= 1'b0;
      r_peak       <= '0;
      r_viol_valid <= 1'b0;
      r_viol_count <= '0;
      r_viol_peak  <= '0;
      r_viol_total <= '0;
    end else begin
      r_over <= w_cmp & en;
      if (en) begin
        r_peak <= w_peak_next;
      end

      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_ARMED;
            r_run   <= '0;
          end
        end
        S_ARMED: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_run   <= '0;
          end else if (w_cmp) begin
            if (r_run == RUN_LAST) begin
              r_state      <= S_REPORT;
              r_run        <= '0;
              r_viol_valid <= 1'b1;
              r_viol_count <= count;
              r_viol_peak  <= w_peak_next;
              if (r_viol_total != '1) begin
                r_viol_total <= r_viol_total + 1'b1;
              end
            end else begin
              r_run <= r_run + 1'b1;
            end
          end else begin
            r_run <= '0;
          end
        end
        S_REPORT: begin
          // Payload is held until accepted; dropping en does not cancel the report.
          if (viol_ready) begin
            r_viol_valid <= 1'b0;
            if (!en) begin
              r_state <= S_IDLE;
            end else if (w_cmp) begin
              r_state <= S_RECOVER;
            end else begin
              r_state <= S_ARMED;
            end
          end
        end
        S_RECOVER: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (!w_cmp) begin
            r_state <= S_ARMED;
            r_run   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign over       = r_over;
  assign peak       = r_peak;
  assign viol_valid = r_viol_valid;
  assign viol_count = r_viol_count;
  assign viol_peak  = r_viol_peak;
  assign viol_total = r_viol_total;

endmodule

// File: tb/tb_count_limit_monitor.sv
// Directed bench for count_limit_monitor: expected reports are queued by the stimulus
// thread and matched by a monitor on each accepted handshake.
module tb_count_limit_monitor;

  logic        clk;
  logic        rst, en, viol_ready;
  logic [31:0] count, max;
  logic        over, viol_valid;
  logic [31:0] peak, viol_count, viol_peak;
  logic [15:0] viol_total;

  logic        rst2, en2, ready2;
  logic [31:0] count2, max2;
  logic        over2, valid2;
  logic [31:0] peak2, vcount2, vpeak2;
  logic [1:0]  total2;

  int checks = 0;
  int errors = 0;
  int reports_seen = 0;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] pk;
    logic [15:0] tot;
  } rep_t;
  rep_t exp_q[$];

  count_limit_monitor #(.WIDTH(32), .HOLD(4), .TOT_W(16)) u_dut (
    .clk_ev(clk), .rst(rst), .en(en), .count(count), .max(max),
    .over(over), .peak(peak), .viol_valid(viol_valid), .viol_ready(viol_ready),
    .viol_count(viol_count), .viol_peak(viol_peak), .viol_total(viol_total)
  );

  count_limit_monitor #(.WIDTH(32), .HOLD(1), .TOT_W(2)) u_sat (
    .clk_ev(clk), .rst(rst2), .en(en2), .count(count2), .max(max2),
    .over(over2), .peak(peak2), .viol_valid(valid2), .viol_ready(ready2),
    .viol_count(vcount2), .viol_peak(vpeak2), .viol_total(total2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_report(input logic [31:0] c, input logic [31:0] p, input logic [15:0] t);
    rep_t r;
    r.cnt = c;
    r.pk  = p;
    r.tot = t;
    exp_q.push_back(r);
  endtask

  // Inputs are stable at the falling edge, so valid & ready here is the next transfer.
  always @(negedge clk) begin
    if (viol_valid === 1'b1 && viol_ready === 1'b1) begin
      reports_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report actual=%0h expected=none", viol_count);
      end else begin
        rep_t r;
        r = exp_q.pop_front();
        chk("sb_viol_count", viol_count, r.cnt);
        chk("sb_viol_peak", viol_peak, r.pk);
        chk("sb_viol_total", viol_total, r.tot);
      end
    end
  end

  initial begin
    int seq1[6];
    seq1 = '{12, 13, 9, 12, 13, 14};
    rst = 1'b1; en = 1'b1; count = 100; max = 10; viol_ready = 1'b1;
    rst2 = 1'b1; en2 = 1'b0; count2 = 0; max2 = 5; ready2 = 1'b1;

    tick(); tick();
    chk("rst_over", over, 0);
    chk("rst_peak", peak, 0);
    chk("rst_valid", viol_valid, 0);
    chk("rst_viol_count", viol_count, 0);
    chk("rst_viol_peak", viol_peak, 0);
    chk("rst_viol_total", viol_total, 0);

    rst = 1'b0; count = 5;
    tick();
    chk("release_valid", viol_valid, 0);

    // Basic violation: 5, 12, 13, 14, 15
    tick();
    chk("basic_over_low", over, 0);
    count = 12; tick();
    chk("basic_over_rise", over, 1);
    count = 13; tick();
    count = 14; tick();
    count = 15; expect_report(15, 15, 1); tick();
    chk("basic_valid", viol_valid, 1);
    chk("basic_viol_count", viol_count, 15);
    chk("basic_viol_peak", viol_peak, 15);
    chk("basic_viol_total", viol_total, 1);
    count = 3; tick();
    chk("basic_valid_one_cycle", viol_valid, 0);

    // Interrupted run
    foreach (seq1[i]) begin
      count = seq1[i]; tick();
      chk("interrupt_no_report", viol_valid, 0);
    end
    count = 15; expect_report(15, 15, 2); tick();
    chk("interrupt_valid", viol_valid, 1);
    chk("interrupt_viol_count", viol_count, 15);

    // Backpressure, then RECOVER
    viol_ready = 1'b0;
    count = 20; tick();
    count = 30; tick();
    count = 50; tick();
    chk("bp_viol_count_held", viol_count, 15);
    chk("bp_peak", peak, 50);
    chk("bp_valid_held", viol_valid, 1);
    viol_ready = 1'b1; tick();
    chk("bp_accept", viol_valid, 0);
    repeat (10) begin
      tick();
      chk("recover_no_report", viol_valid, 0);
    end
    count = 3; tick();
    count = 20;
    repeat (3) tick();
    expect_report(20, 50, 3); tick();
    chk("second_valid", viol_valid, 1);
    chk("second_viol_count", viol_count, 20);
    chk("second_viol_total", viol_total, 3);

    // Negative limit
    count = 3; tick();
    max = 32'hFFFF_FFFF; count = 0;
    repeat (3) tick();
    chk("neg_over", over, 1);
    expect_report(0, 50, 4); tick();
    chk("neg_valid", viol_valid, 1);
    chk("neg_viol_count", viol_count, 0);

    // Zero limit, entered through IDLE
    en = 1'b0; max = 0; tick();
    chk("zero_accept_idle", viol_valid, 0);
    chk("zero_over_disabled", over, 0);
    en = 1'b1; tick();
    repeat (3) tick();
    expect_report(0, 50, 5); tick();
    chk("zero_valid", viol_valid, 1);
    chk("zero_viol_count", viol_count, 0);
    chk("zero_viol_total", viol_total, 5);

    // Disable mid-run clears the run counter
    en = 1'b0; max = 10; count = 10; tick();
    en = 1'b1; tick();
    chk("boundary_over_eq", over, 1);
    tick();
    count = 11; tick();
    en = 1'b0; tick();
    chk("disable_over", over, 0);
    en = 1'b1; count = 9; tick();
    chk("boundary_over_below", over, 0);
    count = 12;
    repeat (3) tick();
    chk("disable_full_hold", viol_valid, 0);
    viol_ready = 1'b0; tick();
    chk("disable_valid", viol_valid, 1);
    chk("disable_viol_count", viol_count, 12);
    chk("disable_viol_peak", viol_peak, 50);
    chk("disable_viol_total", viol_total, 6);

    // Reset while a report is pending
    rst = 1'b1; tick();
    chk("midrst_valid", viol_valid, 0);
    chk("midrst_total", viol_total, 0);
    chk("midrst_peak", peak, 0);
    rst = 1'b0; en = 1'b0;

    // Saturation of the violation counter (HOLD=1, TOT_W=2)
    rst2 = 1'b0; en2 = 1'b1; count2 = 0; tick();
    for (int i = 0; i < 5; i++) begin
      count2 = 9; tick();
      chk("sat_valid", valid2, 1);
      chk("sat_total", total2, (i + 1 > 3) ? 3 : i + 1);
      chk("sat_viol_count", vcount2, 9);
      count2 = 0; tick();
      chk("sat_accept", valid2, 0);
    end

    chk("sb_queue_empty", exp_q.size(), 0);
    chk("sb_reports_seen", reports_seen, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
